// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD job sequencer and its request FIFO.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int GCD_WIDTH = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/gcd_req_fifo.sv
// Request FIFO holding packed operand pairs {a, b}.
// Latency: push visible at head the cycle after the write; pop data is combinational from the head.
// Backpressure: push ignored when full, pop ignored when empty; full/empty derive from the registered count.
module gcd_req_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = 2 * GCD_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [ptr_w(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Queues operand pairs, runs them one at a time on the GCD machine, returns results in order (GCD_TIMEOUT_EN adds a WAIT watchdog).
// Latency: zero-operand result valid the cycle after pop; normal result valid the cycle after gcd_out_en.
// Backpressure: req_ready = !full (registered); rsp_valid/rsp_gcd/rsp_err hold until rsp_ready.
module gcd_job_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH       = GCD_WIDTH,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WIDTH-1:0]        req_a,
    input  logic [WIDTH-1:0]        req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_gcd,
    output logic                    rsp_err,
    output logic                    gcd_go,
    output logic [WIDTH-1:0]        gcd_a,
    output logic [WIDTH-1:0]        gcd_b,
    input  logic                    gcd_done,
    input  logic                    gcd_out_en,
    input  logic [WIDTH-1:0]        gcd_result,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic               full;
    logic               empty;
    logic               pop;

    gcd_req_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data ({req_a, req_b}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign req_ready = !full;
    assign head_a    = head[2*WIDTH-1:WIDTH];
    assign head_b    = head[WIDTH-1:0];
    assign pop       = (state == IDLE) && !empty && gcd_done;
    assign gcd_a     = op_a;
    assign gcd_b     = op_b;

`ifdef GCD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign rsp_err = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            gcd_go    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_gcd   <= '0;
`ifdef GCD_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        op_a <= head_a;
                        op_b <= head_b;
                        // The machine never terminates on a zero operand; answer it here.
                        if (head_a == '0 || head_b == '0) begin
                            rsp_gcd   <= head_a | head_b;
                            rsp_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                            err_q     <= 1'b0;
`endif
                            state     <= RESP;
                        end else begin
                            gcd_go <= 1'b1;
                            state  <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    gcd_go <= 1'b0;
`ifdef GCD_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (gcd_out_en) begin
                        rsp_gcd   <= gcd_result;
                        rsp_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_gcd   <= '0;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed and randomized bench for gcd_job_sequencer with a behavioural GCD machine and an in-order result scoreboard.
module tb_gcd_job_sequencer;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [W-1:0]         req_a = '0;
    logic [W-1:0]         req_b = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [W-1:0]         rsp_gcd;
    logic                 rsp_err;
    logic                 gcd_go;
    logic [W-1:0]         gcd_a;
    logic [W-1:0]         gcd_b;
    logic                 gcd_done = 1'b1;
    logic                 gcd_out_en = 1'b0;
    logic [W-1:0]         gcd_result = '1;
    logic [$clog2(D):0]   fifo_count;

    gcd_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_gcd    (rsp_gcd),
        .rsp_err    (rsp_err),
        .gcd_go     (gcd_go),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_done   (gcd_done),
        .gcd_out_en (gcd_out_en),
        .gcd_result (gcd_result),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          go_cnt = 0;
    int          rsp_cycles = 0;
    bit          hang = 1'b0;
    bit          tmo_mode = 1'b0;
    logic [16:0] expq [$];

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] rnd_op(input int f);
        if ($urandom_range(0, 5) == 0) return '0;
        return W'(f * $urandom_range(1, 60));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural GCD machine: latches operands on go, answers after a random delay unless hung.
    bit           busy = 1'b0;
    int           lat = 0;
    logic [W-1:0] mres = '0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy       = 1'b0;
            gcd_out_en = 1'b0;
            gcd_done   = 1'b1;
        end else begin
            if (gcd_out_en) begin
                gcd_out_en = 1'b0;
                gcd_result = '1;
            end
            if (busy) begin
                if (!hang) begin
                    if (lat == 0) begin
                        gcd_out_en = 1'b1;
                        gcd_done   = 1'b1;
                        gcd_result = mres;
                        busy       = 1'b0;
                    end else begin
                        lat--;
                    end
                end
            end else if (gcd_go) begin
                busy     = 1'b1;
                gcd_done = 1'b0;
                mres     = ref_gcd(gcd_a, gcd_b);
                lat      = $urandom_range(0, 4);
            end
        end
    end

    // Scoreboard: accepted requests queue their expected {err, gcd}; responses pop in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gcd_go) go_cnt++;
            if (rsp_valid) rsp_cycles++;
            if (req_valid && req_ready)
                expq.push_back(tmo_mode ? 17'h10000 : {1'b0, ref_gcd(req_a, req_b)});
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    chk("rsp_unexpected", expq.size(), 1);
                end else begin
                    logic [16:0] e;
                    e = expq.pop_front();
                    chk("sb_rsp_gcd", rsp_gcd, e[15:0]);
                    chk("sb_rsp_err", rsp_err, e[16]);
                end
            end
        end
    end

    task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("push_accept_timeout", ok, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !rsp_valid && fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ok;
        int g0, r0, acc, n, n_sent;
        bit took;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gcd_go", gcd_go, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_gcd", rsp_gcd, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_gcd_a", gcd_a, 0);
        chk("rst_gcd_b", gcd_b, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        // Normal job (48,18)
        rsp_ready = 1'b1;
        push_req(16'd48, 16'd18);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gcd_go) begin ok = 1'b1; break; end
        end
        chk("t1_go_seen", ok, 1);
        chk("t1_gcd_a", gcd_a, 48);
        chk("t1_gcd_b", gcd_b, 18);
        @(negedge clk);
        chk("t1_go_one_cycle", gcd_go, 0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (gcd_out_en) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("t1_out_en_seen", ok, 1);
        chk("t1_no_early_rsp", rsp_valid, 0);
        chk("t1_gcd_a_hold", gcd_a, 48);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_gcd", rsp_gcd, 6);
        drain();

        // Zero-operand bypass
        @(posedge clk); #1 g0 = go_cnt;
        push_req(16'd0, 16'd35);
        @(negedge clk);
        chk("t2_queued", fifo_count, 1);
        chk("t2_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_gcd", rsp_gcd, 35);
        push_req(16'd0, 16'd0);
        @(negedge clk);
        chk("t2b_not_yet", rsp_valid, 0);
        @(negedge clk);
        chk("t2b_rsp_valid", rsp_valid, 1);
        chk("t2b_rsp_gcd", rsp_gcd, 0);
        drain();
        @(posedge clk); #1;
        chk("t2_no_go", go_cnt - g0, 0);

        // Capacity with rsp_ready held low
        rsp_ready = 1'b0;
        acc = 0;
        took = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (took) acc++;
            req_valid = (acc < 7);
            req_a = W'(12 * (acc + 1));
            req_b = W'(8 * (acc + 3));
            @(negedge clk);
            took = req_valid && req_ready;
        end
        chk("t3_accepted", acc, 5);
        chk("t3_req_ready", req_ready, 0);
        chk("t3_fifo_count", fifo_count, 4);
        rsp_ready = 1'b1;
        for (int c = 0; c < 500 && acc < 7; c++) begin
            @(posedge clk); #1;
            if (took) acc++;
            req_valid = (acc < 7);
            req_a = W'(12 * (acc + 1));
            req_b = W'(8 * (acc + 3));
            @(negedge clk);
            took = req_valid && req_ready;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        chk("t3_all_accepted", acc, 7);
        drain();

        // Response held under backpressure
        rsp_ready = 1'b0;
        push_req(16'd42, 16'd63);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("t4_rsp_seen", ok, 1);
        @(posedge clk); #1 g0 = go_cnt;
        push_req(16'd5, 16'd10);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_gcd", rsp_gcd, 21);
        end
        @(posedge clk); #1;
        chk("t4_no_go", go_cnt - g0, 0);
        chk("t4_queued", fifo_count, 1);
        drain();

        // Reset mid-WAIT with three queued
        rsp_ready = 1'b1;
        hang = 1'b1;
        g0 = go_cnt;
        for (int i = 0; i < 4; i++) push_req(W'(6 * (i + 2)), W'(9 * (i + 1)));
        chk("t5_queued", fifo_count, 3);
        chk("t5_launched", go_cnt - g0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_gcd_go", gcd_go, 0);
        chk("t5_rst_fifo_count", fifo_count, 0);
        expq.delete();
        hang = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        g0 = go_cnt;
        r0 = rsp_cycles;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_stale_go", go_cnt - g0, 0);
        chk("t5_no_stale_rsp", rsp_cycles - r0, 0);
        chk("t5_req_ready", req_ready, 1);

`ifdef GCD_TIMEOUT_EN
        // Watchdog: machine hangs, result must be an error after TO WAIT cycles
        hang = 1'b1;
        tmo_mode = 1'b1;
        push_req(16'd9, 16'd6);
        tmo_mode = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gcd_go) begin ok = 1'b1; break; end
        end
        chk("t6_go_seen", ok, 1);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("t6_rsp_seen", ok, 1);
        chk("t6_latency", n, TO + 1);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_rsp_gcd", rsp_gcd, 0);
        push_req(16'd20, 16'd8);
        g0 = go_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_go_while_busy", go_cnt - g0, 0);
        hang = 1'b0;
        drain();
        @(posedge clk); #1;
        chk("t6_relaunch", go_cnt - g0, 1);
`endif

        // Randomized traffic against the scoreboard
        n_sent = 0;
        took = 1'b0;
        for (int c = 0; c < 4000 && (n_sent < 40 || expq.size() > 0); c++) begin
            @(posedge clk); #1;
            if (req_valid && took) begin
                req_valid = 1'b0;
                n_sent++;
            end
            if (!req_valid && n_sent < 40 && $urandom_range(0, 2) != 0) begin
                int f;
                f = $urandom_range(1, 20);
                req_a = rnd_op(f);
                req_b = rnd_op(f);
                req_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = req_ready;
        end
        req_valid = 1'b0;
        chk("rand_all_sent", n_sent, 40);
        drain();
        chk("rand_sb_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
